dot_update_queue: RTL

- Buffers processor MMIO writes to the dot-location window (word addresses 100..999).
- Releases them to the VGA dot table only while the display is blanking, so dot positions never change mid-frame (no tearing).
- Sits between the processor's data-memory port and the VGA controller's dotWren/is_Yloc/dotID/dotLoc inputs, replacing the current combinational decode.
- Single clock domain: the 50 MHz processor clock.

---
 rtl/dot_mmio_pkg.sv | 21 ++
 rtl/dot_update_queue_if.sv | 45 ++++
 rtl/sync_fifo.sv | 75 +++++++
 rtl/dot_update_queue.sv | 117 +++++++++++
 4 files changed

// File: rtl/dot_mmio_pkg.sv
// Shared constants and types for the dot-location MMIO window.
//   X_BASE..Y_BASE-1   : X coordinate of dot (addr - X_BASE)
//   Y_BASE..LAST_ADDR  : Y coordinate of dot (addr - Y_BASE)
//   RNG_ADDR           : random-number read port, never queued
package dot_mmio_pkg;

    localparam int unsigned X_BASE    = 100;
    localparam int unsigned Y_BASE    = 550;
    localparam int unsigned LAST_ADDR = 999;
    localparam int unsigned RNG_ADDR  = 99;
    localparam int unsigned ID_W      = 10;
    localparam int unsigned DATA_W    = 32;

    // One queued dot-table update.
    typedef struct packed {
        logic              is_y;
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] loc;
    } dot_entry_t;

endpackage

// File: rtl/dot_update_queue_if.sv
// Bus bundle between the processor data port / VGA dot table and dot_update_queue.
//   master : drives mem_wren/mem_addr/mem_data/blank, observes queue outputs
//   slave  : the queue itself
// Optional DOT_QUEUE_STATS_EN adds drop_count and high_water.
interface dot_update_queue_if #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ID_W   = 10,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              mem_wren;
    logic [31:0]       mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              blank;
    logic              dotWren;
    logic              is_Yloc;
    logic [ID_W-1:0]   dotID;
    logic [DATA_W-1:0] dotLoc;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;
`ifdef DOT_QUEUE_STATS_EN
    logic [15:0]       drop_count;
    logic [CNT_W-1:0]  high_water;
`endif

    modport master (
        output mem_wren, mem_addr, mem_data, blank,
        input  dotWren, is_Yloc, dotID, dotLoc, full, empty, count, overflow
`ifdef DOT_QUEUE_STATS_EN
        , input drop_count, high_water
`endif
    );

    modport slave (
        input  mem_wren, mem_addr, mem_data, blank,
        output dotWren, is_Yloc, dotID, dotLoc, full, empty, count, overflow
`ifdef DOT_QUEUE_STATS_EN
        , output drop_count, high_water
`endif
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count/full/empty and show-ahead read data.
//   clock, reset  : clock, asynchronous active-high reset (clears pointers/count)
//   i_push/i_data : write request; accepted when not full, or when full and popping
//   i_pop         : read request; ignored when empty
//   o_data        : entry at the read pointer
//   o_full/o_empty/o_count : occupancy, updated on every edge
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             r_empty;

    logic             w_do_push;
    logic             w_do_pop;
    logic [CNT_W-1:0] w_count_next;

    assign w_do_pop  = i_pop && !r_empty;
    // A pop on the same edge frees the slot, so a full FIFO may still accept.
    assign w_do_push = i_push && (!r_full || w_do_pop);

    always_comb begin
        w_count_next = r_count;
        unique case ({w_do_push, w_do_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            // DEPTH is a power of two, so pointers wrap by natural overflow.
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_next;
            r_full  <= (w_count_next == CNT_W'(DEPTH));
            r_empty <= (w_count_next == '0);
        end
    end

    // Storage needs no reset: the pointers define which slots are valid.
    always_ff @(posedge clock) begin
        if (w_do_push) r_mem[r_wptr] <= i_data;
    end

    assign o_data  = r_mem[r_rptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_count = r_count;

endmodule

// File: rtl/dot_update_queue.sv
// Buffers processor writes to the dot-location window and releases them to the VGA
// dot table only during vertical blanking, so dots never move mid-frame.
//   clock, reset : processor clock, asynchronous active-high reset
//   bus (slave)  : mem_wren/mem_addr/mem_data/blank in;
//                  dotWren/is_Yloc/dotID/dotLoc/full/empty/count/overflow out
// Build option DOT_QUEUE_STATS_EN adds drop_count (saturating) and high_water.
module dot_update_queue #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ID_W      = dot_mmio_pkg::ID_W,
    parameter int unsigned DATA_W    = dot_mmio_pkg::DATA_W,
    parameter int unsigned X_BASE    = dot_mmio_pkg::X_BASE,
    parameter int unsigned Y_BASE    = dot_mmio_pkg::Y_BASE,
    parameter int unsigned LAST_ADDR = dot_mmio_pkg::LAST_ADDR
) (
    input  logic             clock,
    input  logic             reset,
    dot_update_queue_if.slave bus
);
    import dot_mmio_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic              is_y;
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] loc;
    } entry_t;

    logic             w_hit;
    logic             w_is_y;
    logic [ID_W-1:0]  w_id;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    entry_t           w_wr_entry;
    entry_t           w_rd_entry;

    logic              r_dot_wren;
    logic              r_is_y;
    logic [ID_W-1:0]   r_id;
    logic [DATA_W-1:0] r_loc;
    logic              r_overflow;

    // Address decode; subtraction at ID_W bits gives the same truncated result.
    assign w_hit  = bus.mem_wren && (bus.mem_addr >= 32'(X_BASE))
                                 && (bus.mem_addr <= 32'(LAST_ADDR));
    assign w_is_y = (bus.mem_addr >= 32'(Y_BASE));
    assign w_id   = w_is_y ? (bus.mem_addr[ID_W-1:0] - ID_W'(Y_BASE))
                           : (bus.mem_addr[ID_W-1:0] - ID_W'(X_BASE));

    assign w_wr_entry = '{is_y: w_is_y, id: w_id, loc: bus.mem_data};
    assign w_pop      = bus.blank && !w_empty;

    sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_hit),
        .i_data  (w_wr_entry),
        .i_pop   (w_pop),
        .o_data  (w_rd_entry),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_dot_wren <= 1'b0;
            r_is_y     <= 1'b0;
            r_id       <= '0;
            r_loc      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_dot_wren <= w_pop;
            if (w_pop) begin
                r_is_y <= w_rd_entry.is_y;
                r_id   <= w_rd_entry.id;
                r_loc  <= w_rd_entry.loc;
            end
            if (w_hit && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

`ifdef DOT_QUEUE_STATS_EN
    logic [15:0]      r_drop_count;
    logic [CNT_W-1:0] r_high_water;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_drop_count <= '0;
            r_high_water <= '0;
        end else begin
            if (w_hit && w_full && !w_pop && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
            if (w_count > r_high_water) r_high_water <= w_count;
        end
    end

    assign bus.drop_count = r_drop_count;
    assign bus.high_water = r_high_water;
`endif

    assign bus.dotWren  = r_dot_wren;
    assign bus.is_Yloc  = r_is_y;
    assign bus.dotID    = r_id;
    assign bus.dotLoc   = r_loc;
    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
    assign bus.count    = w_count;
    assign bus.overflow = r_overflow;

endmodule
